// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_param
// Description : Parametrised sequential radix-2 shift-add multiplier with
//               per-operation signed/unsigned mode, valid/ready handshakes on
//               input and output, and optional early termination once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_param #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    // Iteration counter must hold WIDTH-1; one spare bit keeps the compare simple.
    localparam int c_CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_areg;
    logic [WIDTH-1:0]     r_breg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_y;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_areg_next;
    logic                 w_early_done;
    logic                 w_last_iter;
    logic [2*WIDTH-1:0]   w_y_next;

    // Operand magnitudes. Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1),
    // which is exactly the correct unsigned magnitude.
    assign w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

    // One shift-add step: the multiplicand is shifted into place by the
    // iteration count instead of shifting the accumulator.
    assign w_addend    = r_areg[0] ? ({{WIDTH{1'b0}}, r_breg} << r_cnt) : '0;
    assign w_acc_next  = r_acc + w_addend;
    assign w_areg_next = r_areg >> 1;

    generate
        if (EARLY_TERM) begin : g_early_term
            // Nothing left to add once the shifted multiplier is empty.
            assign w_early_done = (w_areg_next == '0);
        end else begin : g_full_term
            assign w_early_done = 1'b0;
        end
    endgenerate

    assign w_last_iter = (r_cnt == c_CNT_LAST) || w_early_done;

    // Sign is applied once on the way out, in full 2*WIDTH two's complement.
    assign w_y_next = r_neg ? -w_acc_next : w_acc_next;

    // Control FSM and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_areg  <= '0;
            r_breg  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_y     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_areg  <= w_a_mag;
                        r_breg  <= w_b_mag;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_acc  <= w_acc_next;
                    r_areg <= w_areg_next;
                    r_cnt  <= r_cnt + c_CNT_ONE;
                    if (w_last_iter) begin
                        r_y     <= w_y_next;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // New operands are only taken from IDLE, never bypassed here.
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign y         = r_y;

endmodule
`default_nettype wire
